// File: rtl/line_receiver.sv
// line_receiver: collects a valid/ready byte stream into a line buffer,
// presents each terminated line for random-access reading until it is
// acknowledged, counts completed lines and flags lines that were too long.
module line_receiver #(
  parameter int         MAX_LEN    = 16,
  parameter logic [7:0] TERMINATOR = 8'h0A,
  localparam int        LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             line_valid,
  output logic [LEN_W-1:0] line_len,
  input  logic [LEN_W-1:0] rd_index,
  output logic [7:0]       rd_data,
  input  logic             line_ack,
  output logic [31:0]      line_count,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DISCARD = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] line_len_q, line_len_d;
  logic [31:0]      line_count_q, line_count_d;
  logic             overflow_q, overflow_d;
  logic             buf_we;
  logic [7:0]       line_buf_q [MAX_LEN];
  logic             is_term;

  assign is_term    = (in_data == TERMINATOR);

  // Handshake and line presentation depend on state alone, so in_ready
  // never combinationally follows in_valid.
  assign in_ready   = (state_q != S_HOLD);
  assign line_valid = (state_q == S_HOLD);
  assign line_len   = line_len_q;
  assign line_count = line_count_q;
  assign overflow   = overflow_q;

  // Next-state logic: collect, drop an overlong line, or hold for the reader.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    line_len_d   = line_len_q;
    line_count_d = line_count_q;
    overflow_d   = overflow_q;
    buf_we       = 1'b0;
    unique case (state_q)
      S_COLLECT: begin
        if (in_valid) begin
          if (is_term) begin
            line_len_d   = wr_ptr_q;
            line_count_d = line_count_q + 32'd1;
            state_d      = S_HOLD;
          end else if (wr_ptr_q == LEN_W'(MAX_LEN)) begin
            // Buffer already full: this character makes the line overlong.
            overflow_d = 1'b1;
            state_d    = S_DISCARD;
          end else begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + LEN_W'(1);
          end
        end
      end
      S_DISCARD: begin
        // Swallow the rest of the overlong line; no line is presented.
        if (in_valid && is_term) begin
          wr_ptr_d = '0;
          state_d  = S_COLLECT;
        end
      end
      S_HOLD: begin
        if (line_ack) begin
          wr_ptr_d = '0;
          state_d  = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_COLLECT;
      wr_ptr_q     <= '0;
      line_len_q   <= '0;
      line_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      line_len_q   <= line_len_d;
      line_count_q <= line_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Line buffer storage; contents survive reset since line_len gates reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rst_n && buf_we && (wr_ptr_q == LEN_W'(i))) begin
        line_buf_q[i] <= in_data;
      end
    end
  end

  // Read mux: only indices inside the held line return data, else zero.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((rd_index == LEN_W'(i)) && (LEN_W'(i) < line_len_q)) begin
        rd_data = line_buf_q[i];
      end
    end
  end

endmodule

// File: tb/tb_line_receiver.sv
// Bench for line_receiver: directed scenarios followed by random traffic,
// all checked against a queue-based model of the line protocol.
module tb_line_receiver;

  localparam int         MAX_LEN = 16;
  localparam int         LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [7:0] TERM    = 8'h0A;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             line_valid;
  logic [LEN_W-1:0] line_len;
  logic [LEN_W-1:0] rd_index;
  logic [7:0]       rd_data;
  logic             line_ack;
  logic [31:0]      line_count;
  logic             overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: characters of the line being built, the last presented line,
  // and the protocol flags.
  logic [7:0]  mq[$];
  logic [7:0]  mh[$];
  bit          m_hold, m_disc, m_ovf;
  logic [31:0] m_cnt;

  line_receiver #(.MAX_LEN(MAX_LEN), .TERMINATOR(TERM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .line_valid(line_valid), .line_len(line_len),
    .rd_index(rd_index), .rd_data(rd_data), .line_ack(line_ack),
    .line_count(line_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete(); mh.delete();
    m_hold = 0; m_disc = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic m_char(input logic [7:0] c);
    if (c == TERM) begin
      if (m_disc) m_disc = 0;
      else begin
        mh = mq; m_hold = 1; m_cnt = m_cnt + 32'd1;
      end
      mq.delete();
    end else if (!m_disc) begin
      if (mq.size() == MAX_LEN) begin
        m_ovf = 1; m_disc = 1; mq.delete();
      end else mq.push_back(c);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int i);
    return (i < mh.size()) ? mh[i] : 8'h00;
  endfunction

  // One clock: check in_ready before the edge, advance model, check outputs.
  task automatic step();
    bit xf, ak, rs;
    logic [7:0] d;
    chk("in_ready", in_ready, {31'd0, !m_hold});
    xf = in_valid && !m_hold;
    ak = line_ack && m_hold;
    rs = rst_n;
    d  = in_data;
    @(posedge clk); #1;
    if (!rs) m_reset();
    else begin
      if (xf) m_char(d);
      if (ak) m_hold = 0;
    end
    chk("line_valid", line_valid, {31'd0, m_hold});
    chk("line_len", line_len, mh.size());
    chk("line_count", line_count, m_cnt);
    chk("overflow", overflow, {31'd0, m_ovf});
    if (m_hold || mh.size() == 0) begin
      rd_index = LEN_W'($urandom_range(0, MAX_LEN + 1));
      #1;
      chk("rd_data", rd_data, exp_rd(int'(rd_index)));
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      int n = 0;
      in_valid = 1'b1;
      in_data  = s[i];
      while (m_hold && n < 40) begin step(); n++; end
      chk("send_stall", n, 0);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic ack();
    line_ack = 1'b1; step(); line_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; step(); rst_n = 1'b1;
  endtask

  // Compare against literal expectations, independent of the model.
  task automatic expect_line(input string s);
    chk("exp_valid", line_valid, 1);
    chk("exp_len", line_len, s.len());
    for (int i = 0; i <= MAX_LEN; i++) begin
      rd_index = LEN_W'(i); #1;
      chk("exp_rd", rd_data, (i < s.len()) ? s[i] : 8'h00);
    end
  endtask

  task automatic expect_reads_zero();
    for (int i = 0; i <= MAX_LEN; i++) begin
      rd_index = LEN_W'(i); #1;
      chk("rd_zero", rd_data, 0);
    end
  endtask

  initial begin
    string sa, sb;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; line_ack = 1'b0; rd_index = '0;
    @(posedge clk); #1;
    m_reset();
    rst_n = 1'b1;
    chk("rst_valid", line_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_len", line_len, 0);
    chk("rst_count", line_count, 0);
    chk("rst_ovf", overflow, 0);
    expect_reads_zero();

    send("hello world!\n");
    expect_line("hello world!");
    chk("count1", line_count, 1);

    // Source keeps offering while held: nothing may transfer.
    in_valid = 1'b1; in_data = "x";
    repeat (10) step();
    in_valid = 1'b0;
    expect_line("hello world!");
    chk("count_hold", line_count, 1);
    ack();
    send("hello world!\n");
    expect_line("hello world!");
    chk("count2", line_count, 2);
    ack();

    sa = ""; for (int i = 0; i < MAX_LEN; i++) sa = {sa, "a"};
    send({sa, "\n"});
    expect_line(sa);
    chk("full_ovf", overflow, 0);
    ack();
    sb = ""; for (int i = 0; i < 20; i++) sb = {sb, "b"};
    send({sb, "\n"});
    chk("long_valid", line_valid, 0);
    chk("long_ovf", overflow, 1);
    chk("long_count", line_count, 3);
    send("ok\n");
    expect_line("ok");
    chk("ok_count", line_count, 4);
    ack();

    send("\n"); chk("empty1_len", line_len, 0); chk("empty1_v", line_valid, 1); ack();
    send("\n"); chk("empty2_len", line_len, 0); chk("empty2_v", line_valid, 1); ack();
    chk("empty_count", line_count, 6);

    send("hel");
    pulse_reset();
    chk("mid_rst_count", line_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    expect_reads_zero();
    send("hi\n");
    expect_line("hi");
    pulse_reset();
    chk("hold_rst_valid", line_valid, 0);
    chk("hold_rst_len", line_len, 0);
    expect_reads_zero();
    send("hi\n");
    expect_line("hi");
    ack();

    // Preload the line counter just below wrap.
    force dut.line_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.line_count_q;
    m_cnt = 32'hFFFF_FFFF;
    step();
    chk("pre_wrap", line_count, 32'hFFFF_FFFF);
    send("\n");
    chk("wrap", line_count, 0);
    ack();

    for (int c = 0; c < 3000; c++) begin
      int r;
      rst_n    = ($urandom_range(0, 299) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      r        = $urandom_range(0, 11);
      in_data  = (r == 0) ? TERM : (r == 1) ? 8'h00 : 8'(8'h61 + r);
      line_ack = ($urandom_range(0, 2) == 0);
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; line_ack = 1'b0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/line_receiver.md
Name: line_receiver

Overview:
- Consumer end of the byte-stream message interface: accepts 8-bit characters under a valid/ready handshake and assembles them into a line buffer until a terminator character arrives.
- Presents each completed line (length plus random-access read port) to a downstream reader, which releases it with an acknowledge.
- Counts completed lines and flags overlong lines.
- Sits after any character source (e.g. the "hello world!\n" message generator) as its checker/collector in the debugger example designs.

Parameters:
- MAX_LEN, 16, line buffer capacity in characters, excluding terminator; legal range 1..255.
- TERMINATOR, 8'h0A, character that ends a line; not stored.
- LEN_W, $clog2(MAX_LEN+1), width of length and index ports; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  source presents a character.
- in_data  input  8  character.
- in_ready  output  1  receiver accepts the character this cycle.
- line_valid  output  1  a completed line is held for reading.
- line_len  output  LEN_W  character count of the held line (0..MAX_LEN).
- rd_index  input  LEN_W  read address into the held line.
- rd_data  output  8  character at rd_index (combinational).
- line_ack  input  1  reader releases the held line.
- line_count  output  32  completed lines since reset.
- overflow  output  1  sticky: a line exceeding MAX_LEN was dropped.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=COLLECT, wr_ptr=0, line_len=0, line_valid=0, line_count=0, overflow=0.
  - Buffer contents are not cleared.
  - Reset overrides every other input the same cycle; a line in progress or held is lost.
- Handshake: a character transfers when in_valid && in_ready at posedge. in_ready is a function of state only, never of in_valid.
- State COLLECT (in_ready=1, line_valid=0):
  - On transfer with in_data==TERMINATOR: line_len<=wr_ptr, line_count<=line_count+1, go HOLD. line_valid rises the cycle after the terminator transfer (1-cycle latency).
  - On transfer with a non-terminator and wr_ptr<MAX_LEN: buf[wr_ptr]<=in_data, wr_ptr<=wr_ptr+1.
  - On transfer with a non-terminator and wr_ptr==MAX_LEN: overflow<=1, go DISCARD; the character is dropped.
- State DISCARD (in_ready=1, line_valid=0):
  - Non-terminator characters are accepted and dropped.
  - On the terminator: wr_ptr<=0, go COLLECT.
  - line_count is not incremented; no line is presented.
- State HOLD (in_ready=0, line_valid=1):
  - buf and line_len are stable.
  - On line_ack: wr_ptr<=0, go COLLECT. line_valid falls and in_ready rises the next cycle.
  - The source stalls while in HOLD; no character is lost.
- line_ack while line_valid=0 is ignored.
- Read port: rd_data=buf[rd_index] when rd_index<line_len, else 8'h00. After reset rd_data=0 for all indices.
- Empty line (terminator with wr_ptr=0): valid line, line_len=0, counted.
- Exactly MAX_LEN characters followed by the terminator: valid line, line_len=MAX_LEN, no overflow.
- line_count wraps 32'hFFFFFFFF -> 0.
- overflow clears only on reset.
- Each state is legal for any in_data value, including 8'h00; only TERMINATOR is special.

Test Plan:
- After reset, drive "hello world!\n" with in_valid=1 every cycle -> 13 transfers; line_valid=1 one cycle after the '\n' transfer, line_len=12; rd_index 0..11 reads "hello world!"; rd_index 12 reads 8'h00; line_count=1; overflow=0.
- Hold line_ack=0 for 10 cycles with in_valid=1 -> in_ready=0 throughout, line_count and buffer unchanged. Pulse line_ack -> in_ready=1 the next cycle; a second "hello world!\n" yields line_count=2 and identical readback.
- MAX_LEN=16: send 16 'a' then '\n' -> line_len=16, overflow=0. Then send 20 'b' then '\n' -> no line_valid, overflow=1, line_count unchanged. Then "ok\n" -> line_len=2, reads "ok".
- Back-to-back terminators "\n\n" with line_ack asserted each time line_valid rises -> two lines with line_len=0; line_count increments by 2.
- Assert rst_n=0 for one cycle midway through "hello" and again while in HOLD -> all outputs return to reset values the next cycle, rd_data=0; a subsequent "hi\n" produces line_len=2.
- Force line_count to 32'hFFFFFFFF via 2^32-1 empty lines (or a preloaded bench backdoor), then one more line -> line_count=0.
